// File: rtl/spi_arb_pkg.sv
// Shared types for the SPI bus arbiter: FSM state encoding and index-width helper.
package spi_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    GUARD = 2'd2
  } arb_state_t;

  // Width of an index into n requesters, never less than one bit.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set req bit scanning upward from last+1, wrapping.
// Zero latency; valid is low when no request is set.
module rr_pick
  import spi_arb_pkg::*;
#(
  parameter int NUM_REQ = 3,
  parameter int IW      = idx_w(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IW-1:0]      last,
  output logic               valid,
  output logic [IW-1:0]      idx
);

  int cand;

  // Scan from farthest to nearest so the nearest set bit after last wins.
  always_comb begin
    valid = 1'b0;
    idx   = '0;
    cand  = 0;
    for (int i = NUM_REQ; i >= 1; i--) begin
      cand = (int'(last) + i) % NUM_REQ;
      if (req[cand]) begin
        valid = 1'b1;
        idx   = IW'(cand);
      end
    end
  end

endmodule

// File: rtl/spi_bus_arbiter.sv
// Round-robin owner of one shared SPI bus; owner's clk/mosi/ncs reach the pins one cycle late.
// Grant is held until the owner drops req, then a guard gap with all selects high precedes the next grant.
module spi_bus_arbiter
  import spi_arb_pkg::*;
#(
  parameter int   NUM_REQ      = 3,
  parameter int   GUARD_CYCLES = 4,
  parameter logic IDLE_CLK     = 1'b0
) (
  input  logic                        clk,
  input  logic                        nrst,
  input  logic [NUM_REQ-1:0]          req,
  output logic [NUM_REQ-1:0]          gnt,
  input  logic [NUM_REQ-1:0]          req_spi_clk,
  input  logic [NUM_REQ-1:0]          req_spi_mosi,
  input  logic [NUM_REQ-1:0]          req_spi_ncs,
  output logic [NUM_REQ-1:0]          req_spi_miso,
  output logic                        spi_clk,
  output logic                        spi_mosi,
  input  logic                        spi_miso,
  output logic [NUM_REQ-1:0]          dev_ncs,
  output logic [idx_w(NUM_REQ)-1:0]   owner,
  output logic                        busy
);

  localparam int IW = idx_w(NUM_REQ);
  localparam int CW = (GUARD_CYCLES > 1) ? $clog2(GUARD_CYCLES) : 1;

  arb_state_t           state, state_nxt;
  logic [IW-1:0]        owner_nxt;
  logic [NUM_REQ-1:0]   gnt_nxt, ncs_nxt;
  logic [CW-1:0]        cnt, cnt_nxt;
  logic                 clk_nxt, mosi_nxt;
  logic                 pick_vld;
  logic [IW-1:0]        pick_idx;

  rr_pick #(.NUM_REQ(NUM_REQ), .IW(IW)) u_pick (
    .req   (req),
    .last  (owner),
    .valid (pick_vld),
    .idx   (pick_idx)
  );

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state    <= IDLE;
      owner    <= IW'(NUM_REQ - 1);
      gnt      <= '0;
      cnt      <= '0;
      spi_clk  <= IDLE_CLK;
      spi_mosi <= 1'b0;
      dev_ncs  <= '1;
    end else begin
      state    <= state_nxt;
      owner    <= owner_nxt;
      gnt      <= gnt_nxt;
      cnt      <= cnt_nxt;
      spi_clk  <= clk_nxt;
      spi_mosi <= mosi_nxt;
      dev_ncs  <= ncs_nxt;
    end
  end

  // Pins fall back to idle levels in every cycle that is not an active GRANT.
  always_comb begin
    state_nxt = state;
    owner_nxt = owner;
    gnt_nxt   = gnt;
    cnt_nxt   = cnt;
    clk_nxt   = IDLE_CLK;
    mosi_nxt  = 1'b0;
    ncs_nxt   = '1;
    case (state)
      IDLE: begin
        if (pick_vld) begin
          state_nxt          = GRANT;
          owner_nxt          = pick_idx;
          gnt_nxt            = '0;
          gnt_nxt[pick_idx]  = 1'b1;
        end
      end
      GRANT: begin
        if (!req[owner]) begin
          state_nxt = GUARD;
          gnt_nxt   = '0;
          cnt_nxt   = CW'(GUARD_CYCLES - 1);
        end else begin
          clk_nxt          = req_spi_clk[owner];
          mosi_nxt         = req_spi_mosi[owner];
          ncs_nxt[owner]   = req_spi_ncs[owner];
        end
      end
      GUARD: begin
        if (cnt == '0) state_nxt = IDLE;
        else           cnt_nxt   = cnt - CW'(1);
      end
      default: state_nxt = IDLE;
    endcase
  end

  // gnt is one-hot only during GRANT, so it doubles as the MISO steering mask.
  assign req_spi_miso = gnt & {NUM_REQ{spi_miso}};
  assign busy         = (state != IDLE);

endmodule

// File: doc/spi_bus_arbiter.md
Name: spi_bus_arbiter

Overview:
Shares one physical SPI bus (spi_clk, spi_mosi, spi_miso) between NUM_REQ independent SPI masters, e.g. OledCtrl, a PSRAM engine and a flash loader. Requesters use a req/gnt handshake. Arbitration is round-robin. The owner's SPI signals are muxed onto the pins, and the owner's ncs is routed to its own device select. A guard interval with every select deasserted separates consecutive owners. The block sits in the top level, between the controllers and the lcd_cs_n / psram_cs_n / flash_cs_n pins.

Parameters:
NUM_REQ, 3, number of requesters and device selects (2..8)
GUARD_CYCLES, 4, idle clk cycles between owners with all selects high (>=1)
IDLE_CLK, 1'b0, level driven on spi_clk when no requester owns the bus (CPOL)

Ports:
clk  in  1  system clock
nrst  in  1  asynchronous active-low reset
req  in  NUM_REQ  per-requester bus request, level
gnt  out  NUM_REQ  per-requester grant, one-hot or zero, registered
req_spi_clk  in  NUM_REQ  per-requester SPI clock
req_spi_mosi  in  NUM_REQ  per-requester MOSI
req_spi_ncs  in  NUM_REQ  per-requester chip select, active low
req_spi_miso  out  NUM_REQ  MISO to each requester; 0 unless owner
spi_clk  out  1  shared SPI clock pin
spi_mosi  out  1  shared MOSI pin
spi_miso  in  1  shared MISO pin
dev_ncs  out  NUM_REQ  per-device chip select, active low
owner  out  $clog2(NUM_REQ)  index of current/last owner
busy  out  1  1 when state != IDLE

Behaviour:
- Reset (nrst low, asynchronous):
  - gnt=0, dev_ncs=all 1, spi_clk=IDLE_CLK, spi_mosi=0.
  - owner=NUM_REQ-1, so req[0] wins the first tie.
  - guard counter=0, state=IDLE.
- States: IDLE, GRANT, GUARD.
- IDLE:
  - If any req bit is set, pick the first set bit scanning upward from owner+1, wrapping modulo NUM_REQ.
  - Next cycle: owner=pick, gnt[pick]=1, state=GRANT.
  - If no req bit is set, stay in IDLE.
- GRANT:
  - Registered mux, 1 clk latency from input to pin:
    - spi_clk <= req_spi_clk[owner]
    - spi_mosi <= req_spi_mosi[owner]
    - dev_ncs[owner] <= req_spi_ncs[owner]
    - all other dev_ncs <= 1
  - req_spi_miso[owner] = spi_miso, combinational. All other req_spi_miso bits are 0.
  - Requests from non-owners are ignored. There is no preemption.
  - When req[owner]==0 is sampled:
    - next cycle gnt=0, dev_ncs=all 1, spi_clk=IDLE_CLK, spi_mosi=0
    - counter loaded with GUARD_CYCLES-1, state=GUARD.
  - If req drops while the owner's ncs is still low, the transfer is truncated: dev_ncs goes high in that same transition. The requester is responsible for releasing req only after it raises ncs.
- GUARD:
  - Outputs held at idle values. Counter decrements each cycle.
  - When the counter reaches 0, state=IDLE.
  - Arbitration happens in IDLE, so the minimum gap from the last owner cycle to the next gnt is GUARD_CYCLES+1 cycles.
- Requester contract: drive spi_clk/mosi only while gnt is high. The block does not check this; ungranted inputs are simply ignored.
- Simultaneous events:
  - Owner drops req in the same cycle another requester raises req: GUARD is still entered.
  - The same requester re-requesting immediately is served only if no other req is pending after GUARD (round-robin fairness).
- owner keeps the last granted index while in GUARD and IDLE. This keeps the round-robin pointer.
- No combinational path from req to gnt.

Decomposition:
- Package spi_arb_pkg:
  - state enum (IDLE, GRANT, GUARD)
  - owner index width helper
- Sub-module rr_pick: purely combinational round-robin picker.
  - Inputs: req[NUM_REQ], last[$clog2(NUM_REQ)].
  - Outputs: valid, idx.
  - Reused by future shared-resource arbiters.

Test Plan:
- Reset: nrst low mid-GRANT (owner=1, dev_ncs[1]=0) -> immediately gnt=0, dev_ncs=3'b111, spi_clk=IDLE_CLK, owner=2, busy=0.
- Single requester: req=3'b001 at cycle 0 -> gnt=3'b001 at cycle 1. req_spi_clk[0] toggles reach spi_clk one cycle later. dev_ncs[0] follows req_spi_ncs[0]; dev_ncs[2:1] stay 1.
- Round robin: req=3'b111 held, each owner releases after 10 cycles -> grant order 0,1,2,0. Gap from each gnt fall to the next gnt rise is GUARD_CYCLES+1=5 cycles with dev_ncs=3'b111 throughout.
- Non-preemption: owner 2 granted, req[0] raised -> gnt stays 3'b100 until req[2] falls, then gnt=3'b001 after the guard.
- MISO isolation: owner=1, spi_miso=1 -> req_spi_miso=3'b010. In GUARD, req_spi_miso=3'b000.
- Truncation: owner 0 drops req while req_spi_ncs[0]=0 -> dev_ncs[0]=1 on the next cycle, state GUARD, no glitch on dev_ncs[2:1].
